// File: rtl/reg_file_mp.sv
// Multi-ported register file: two combinational read ports, two write ports
// (port B has priority) and a pending-producer scoreboard with optional forwarding.
module reg_file_mp #(
    parameter int XLEN   = 32,
    parameter int DEPTH  = 32,
    parameter int AW     = $clog2(DEPTH),
    parameter int BYPASS = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [AW-1:0]   ra1,
    input  logic [AW-1:0]   ra2,
    output logic [XLEN-1:0] rd1,
    output logic [XLEN-1:0] rd2,
    input  logic            we_a,
    input  logic [AW-1:0]   wa_a,
    input  logic [XLEN-1:0] wd_a,
    input  logic            we_b,
    input  logic [AW-1:0]   wa_b,
    input  logic [XLEN-1:0] wd_b,
    input  logic            sb_set,
    input  logic [AW-1:0]   sb_addr,
    output logic            busy1,
    output logic            busy2
);

    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [XLEN-1:0] mem [DEPTH];
    logic [DEPTH-1:0] sb;
    logic             armed;
    logic             wen_a;
    logic             wen_b;
    logic             set_en;

    // Address 0 and anything beyond DEPTH never hold state.
    function automatic logic valid_addr(input logic [AW-1:0] a);
        return (a != '0) && (int'(a) < DEPTH);
    endfunction

    function automatic logic [IW-1:0] idx(input logic [AW-1:0] a);
        return a[IW-1:0];
    endfunction

    // armed stays low through the first edge after reset release, so a write
    // presented on that edge is dropped rather than racing the deassertion.
    assign wen_a  = armed & we_a   & valid_addr(wa_a);
    assign wen_b  = armed & we_b   & valid_addr(wa_b);
    assign set_en = armed & sb_set & valid_addr(sb_addr);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            armed <= 1'b0;
            sb    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            armed <= 1'b1;
            // Later non-blocking assignments win: port B over port A, and a
            // new producer's set over a completing write's clear.
            if (wen_a) begin
                mem[idx(wa_a)] <= wd_a;
                sb[idx(wa_a)]  <= 1'b0;
            end
            if (wen_b) begin
                mem[idx(wa_b)] <= wd_b;
                sb[idx(wa_b)]  <= 1'b0;
            end
            if (set_en) begin
                sb[idx(sb_addr)] <= 1'b1;
            end
        end
    end

    function automatic logic [XLEN-1:0] read_data(input logic [AW-1:0] ra);
        if (!valid_addr(ra)) return '0;
        if (BYPASS != 0 && wen_b && wa_b == ra) return wd_b;
        if (BYPASS != 0 && wen_a && wa_a == ra) return wd_a;
        return mem[idx(ra)];
    endfunction

    function automatic logic read_busy(input logic [AW-1:0] ra);
        if (!valid_addr(ra)) return 1'b0;
        if (BYPASS != 0 && ((wen_a && wa_a == ra) || (wen_b && wa_b == ra))) return 1'b0;
        return sb[idx(ra)];
    endfunction

    always_comb begin
        rd1   = read_data(ra1);
        rd2   = read_data(ra2);
        busy1 = read_busy(ra1);
        busy2 = read_busy(ra2);
    end

endmodule
